// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Front-end sequencer that runs after an EX-stage branch resolves.
//   On a taken branch it kills the wrong-path IF/ID instructions, stalls EX,
//   and raises a valid/ready redirect to fetch. Once fetch accepts, it holds
//   the flush for SQUASH_CYCLES more cycles. Not-taken branches need no action.
//
//   Optional feature: define BRANCH_STATS_EN to build the two branch
//   statistics counters. Without it, both stat ports are tied to zero.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   br_valid_i        branch resolved in EX this cycle
//   br_taken_i        branch decision
//   br_target_i       branch target address (latched as-is, all 32 bits)
//   redirect_valid_o  redirect request to fetch
//   redirect_ready_i  fetch accepts the redirect
//   redirect_pc_o     new fetch PC
//   flush_if_o        kill IF-stage instruction
//   flush_id_o        kill ID-stage instruction
//   ex_stall_o        hold EX so that no new branch can resolve
//   busy_o            sequencer is not idle
//   stat_resolved_o   branches accepted in IDLE (BRANCH_STATS_EN only)
//   stat_taken_o      taken branches accepted (BRANCH_STATS_EN only)
module branch_redirect_ctrl #(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             ex_stall_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stat_resolved_o,
    output logic [CNT_W-1:0] stat_taken_o
);

    // The counter holds at most SQUASH_CYCLES-1. Keep it at least 1 bit wide.
    localparam int unsigned CW = (SQUASH_CYCLES > 2) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [CW-1:0] SQ_LOAD = (SQUASH_CYCLES > 0) ? CW'(SQUASH_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   squash_cnt;
    logic            accept;
    logic            take;

    // A branch is only accepted while idle; EX is stalled at all other times.
    assign accept = (state == IDLE) && br_valid_i;
    assign take   = accept && br_taken_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            redirect_pc_o <= '0;
            squash_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                redirect_pc_o <= br_target_i;
            end
            if ((state == REQ) && redirect_ready_i) begin
                squash_cnt <= SQ_LOAD;
            end else if ((state == SQUASH) && (squash_cnt != '0)) begin
                squash_cnt <= squash_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        redirect_valid_o = 1'b0;
        flush_if_o       = 1'b0;
        flush_id_o       = 1'b0;
        ex_stall_o       = 1'b0;
        busy_o           = 1'b0;
        case (state)
            IDLE: begin
                // Same-cycle kill of the wrong-path instructions. The kill is
                // gated by rst so that all 1-bit outputs stay low during reset.
                flush_if_o = take && !rst;
                flush_id_o = take && !rst;
                if (take) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                redirect_valid_o = 1'b1;
                flush_if_o       = 1'b1;
                flush_id_o       = 1'b1;
                ex_stall_o       = 1'b1;
                busy_o           = 1'b1;
                if (redirect_ready_i) begin
                    state_nxt = (SQUASH_CYCLES == 0) ? IDLE : SQUASH;
                end
            end
            SQUASH: begin
                flush_if_o = 1'b1;
                flush_id_o = 1'b1;
                ex_stall_o = 1'b1;
                busy_o     = 1'b1;
                if (squash_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] taken_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolved_cnt <= '0;
            taken_cnt    <= '0;
        end else begin
            if (accept) begin
                resolved_cnt <= resolved_cnt + 1'b1;
            end
            if (take) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

    assign stat_resolved_o = resolved_cnt;
    assign stat_taken_o    = taken_cnt;
`else
    assign stat_resolved_o = '0;
    assign stat_taken_o    = '0;
`endif

    // A branch resolving while busy is dropped; EX should have been stalled.
    a_no_branch_while_busy: assert property (
        @(posedge clk) disable iff (rst) !(br_valid_i && busy_o)
    ) else $error("br_valid_i asserted while busy_o");

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ready;

    // Instance A: SQUASH_CYCLES=2, CNT_W=32
    logic        a_valid, a_fif, a_fid, a_stall, a_busy;
    logic [31:0] a_pc, a_sres, a_stkn;
    // Instance B: SQUASH_CYCLES=0, CNT_W=4
    logic        b_valid, b_fif, b_fid, b_stall, b_busy;
    logic [31:0] b_pc;
    logic [3:0]  b_sres, b_stkn;

    int checks = 0;
    int errors = 0;

    branch_redirect_ctrl #(.SQUASH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .br_valid_i(br_valid), .br_taken_i(br_taken), .br_target_i(br_target),
        .redirect_valid_o(a_valid), .redirect_ready_i(ready), .redirect_pc_o(a_pc),
        .flush_if_o(a_fif), .flush_id_o(a_fid), .ex_stall_o(a_stall), .busy_o(a_busy),
        .stat_resolved_o(a_sres), .stat_taken_o(a_stkn)
    );

    branch_redirect_ctrl #(.SQUASH_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .br_valid_i(br_valid), .br_taken_i(br_taken), .br_target_i(br_target),
        .redirect_valid_o(b_valid), .redirect_ready_i(ready), .redirect_pc_o(b_pc),
        .flush_if_o(b_fif), .flush_id_o(b_fid), .ex_stall_o(b_stall), .busy_o(b_busy),
        .stat_resolved_o(b_sres), .stat_taken_o(b_stkn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic f, input logic s, input logic b);
        chk({tag, ".a_valid"}, {31'b0, a_valid}, {31'b0, v});
        chk({tag, ".a_flush_if"}, {31'b0, a_fif}, {31'b0, f});
        chk({tag, ".a_flush_id"}, {31'b0, a_fid}, {31'b0, f});
        chk({tag, ".a_stall"}, {31'b0, a_stall}, {31'b0, s});
        chk({tag, ".a_busy"}, {31'b0, a_busy}, {31'b0, b});
    endtask

    task automatic chk_b(input string tag, input logic v, input logic f, input logic s, input logic b);
        chk({tag, ".b_valid"}, {31'b0, b_valid}, {31'b0, v});
        chk({tag, ".b_flush_if"}, {31'b0, b_fif}, {31'b0, f});
        chk({tag, ".b_flush_id"}, {31'b0, b_fid}, {31'b0, f});
        chk({tag, ".b_stall"}, {31'b0, b_stall}, {31'b0, s});
        chk({tag, ".b_busy"}, {31'b0, b_busy}, {31'b0, b});
    endtask

    // Taken branch with ready held high; returns once both instances are idle.
    task automatic run_taken(input logic [31:0] tgt);
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_target = tgt; ready = 1'b1;
        @(negedge clk);
        br_valid = 1'b0; br_taken = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_not_taken(input logic [31:0] tgt);
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b0; br_target = tgt;
        @(negedge clk);
        br_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0;
        // A taken branch presented during reset must neither flush nor latch.
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        chk_a("reset", 0, 0, 0, 0);
        chk_b("reset", 0, 0, 0, 0);
        chk("reset.a_pc", a_pc, 32'h0);
        chk("reset.b_pc", b_pc, 32'h0);
        chk("reset.a_sres", a_sres, 32'h0);
        @(negedge clk);
        rst = 1'b0; br_valid = 1'b0; br_taken = 1'b0;

        // Not-taken branch: no action at all.
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b0; br_target = 32'h0000_1234; #1;
        chk_a("nt", 0, 0, 0, 0);
        chk_b("nt", 0, 0, 0, 0);
        @(negedge clk);
        br_valid = 1'b0; #1;
        chk_a("nt_next", 0, 0, 0, 0);
        chk("nt_next.a_pc", a_pc, 32'h0);
        chk("nt_next.b_pc", b_pc, 32'h0);

        // Taken branch, ready=1: combinational flush in cycle N.
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_8000; ready = 1'b1; #1;
        chk_a("tk_n", 0, 1, 0, 0);
        chk_b("tk_n", 0, 1, 0, 0);
        @(negedge clk);
        br_valid = 1'b0; br_taken = 1'b0; #1;
        chk_a("tk_n1", 1, 1, 1, 1);
        chk("tk_n1.a_pc", a_pc, 32'h0000_8000);
        chk_b("tk_n1", 1, 1, 1, 1);
        chk("tk_n1.b_pc", b_pc, 32'h0000_8000);
        @(negedge clk); #1;
        chk_a("tk_n2", 0, 1, 1, 1);
        chk_b("tk_n2", 0, 0, 0, 0);
        @(negedge clk); #1;
        chk_a("tk_n3", 0, 1, 1, 1);
        @(negedge clk); #1;
        chk_a("tk_n4", 0, 0, 0, 0);
        chk("tk_n4.a_pc", a_pc, 32'h0000_8000);

        // Fetch backpressure: ready low for 5 cycles, high on the 6th.
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'hDEAD_BEE0; ready = 1'b0; #1;
        chk_a("bp_n", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            br_valid = 1'b0; br_taken = 1'b0; br_target = 32'h0; #1;
            chk_a("bp_hold", 1, 1, 1, 1);
            chk("bp_hold.a_pc", a_pc, 32'hDEAD_BEE0);
            chk_b("bp_hold", 1, 1, 1, 1);
            chk("bp_hold.b_pc", b_pc, 32'hDEAD_BEE0);
        end
        @(negedge clk);
        ready = 1'b1; #1;
        chk_a("bp_acc", 1, 1, 1, 1);
        chk("bp_acc.a_pc", a_pc, 32'hDEAD_BEE0);
        @(negedge clk); #1;
        chk_a("bp_sq1", 0, 1, 1, 1);
        chk_b("bp_sq1", 0, 0, 0, 0);
        @(negedge clk); #1;
        chk_a("bp_sq2", 0, 1, 1, 1);
        @(negedge clk); #1;
        chk_a("bp_done", 0, 0, 0, 0);

        // Asynchronous reset in the middle of SQUASH, away from any clock edge.
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_4000;
        @(negedge clk);
        br_valid = 1'b0; br_taken = 1'b0;
        @(negedge clk); #1;
        chk_a("rs_pre", 0, 1, 1, 1);
        #2 rst = 1'b1;
        #1;
        chk_a("rs_async", 0, 0, 0, 0);
        chk("rs_async.a_pc", a_pc, 32'h0);
        chk_b("rs_async", 0, 0, 0, 0);
        chk("rs_async.b_pc", b_pc, 32'h0);
        chk("rs_async.a_sres", a_sres, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequencing after reset is normal.
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_5000; ready = 1'b1; #1;
        chk_a("ar_n", 0, 1, 0, 0);
        @(negedge clk);
        br_valid = 1'b0; br_taken = 1'b0; #1;
        chk_a("ar_n1", 1, 1, 1, 1);
        chk("ar_n1.a_pc", a_pc, 32'h0000_5000);
        @(negedge clk); #1;
        chk_a("ar_n2", 0, 1, 1, 1);
        chk_b("ar_n2", 0, 0, 0, 0);
        @(negedge clk); #1;
        chk_a("ar_n3", 0, 1, 1, 1);
        @(negedge clk); #1;
        chk_a("ar_n4", 0, 0, 0, 0);

        // Statistics since reset: 1 taken so far; add 2 taken and 2 not-taken.
        run_taken(32'h0000_6000);
        run_not_taken(32'h0000_7000);
        run_taken(32'h0000_9000);
        run_not_taken(32'h0000_A000);
        #1;
        chk("tk3.a_pc", a_pc, 32'h0000_9000);
`ifdef BRANCH_STATS_EN
        chk("st5.a_res", a_sres, 32'd5);
        chk("st5.a_tkn", a_stkn, 32'd3);
        chk("st5.b_res", {28'b0, b_sres}, 32'd5);
        chk("st5.b_tkn", {28'b0, b_stkn}, 32'd3);
`else
        chk("st5.a_res", a_sres, 32'd0);
        chk("st5.a_tkn", a_stkn, 32'd0);
        chk("st5.b_res", {28'b0, b_sres}, 32'd0);
`endif

        // 12 more back-to-back not-taken resolutions: 17 in total.
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b0;
        repeat (12) @(negedge clk);
        br_valid = 1'b0; #1;
        chk_a("nt12", 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
        chk("st17.a_res", a_sres, 32'd17);
        chk("st17.a_tkn", a_stkn, 32'd3);
        chk("st17.b_res", {28'b0, b_sres}, 32'd1);
        chk("st17.b_tkn", {28'b0, b_stkn}, 32'd3);
`else
        chk("st17.a_res", a_sres, 32'd0);
        chk("st17.b_tkn", {28'b0, b_stkn}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the front end after the EX-stage branch decision (branch_taken/branch_pc) is resolved.
- On a taken branch: squashes wrong-path instructions in IF/ID, stalls EX, issues a valid/ready redirect request to the fetch unit, then holds the flush for a fixed refill window.
- Not-taken branches pass through with no action.

Parameters:
- SQUASH_CYCLES, 2, cycles the flush is held after the fetch unit accepts the redirect (0 = return to idle immediately on acceptance).
- CNT_W, 32, width of the statistics counters (used only when the optional feature is compiled in).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- br_valid_i  in  1  branch instruction resolved in EX this cycle
- br_taken_i  in  1  branch decision from the branch unit
- br_target_i  in  32  branch target address
- redirect_valid_o  out  1  redirect request to fetch
- redirect_ready_i  in  1  fetch accepts redirect
- redirect_pc_o  out  32  new fetch PC
- flush_if_o  out  1  kill IF-stage instruction
- flush_id_o  out  1  kill ID-stage instruction
- ex_stall_o  out  1  hold EX; no new branch may resolve
- busy_o  out  1  FSM not in IDLE
- stat_resolved_o  out  CNT_W  branches resolved (optional feature only)
- stat_taken_o  out  CNT_W  taken branches (optional feature only)

Behaviour:
- Reset (async, rst=1): state=IDLE, redirect_pc_o=0, squash counter=0, stat counters=0. All 1-bit outputs are 0 while in reset.
- FSM states: IDLE, REQ, SQUASH.
- IDLE:
  - Outputs are 0, except that flush_if_o and flush_id_o are driven combinationally by (br_valid_i & br_taken_i), giving a same-cycle kill.
  - On br_valid_i & br_taken_i: latch br_target_i into redirect_pc_o; next state is REQ.
  - On br_valid_i & !br_taken_i: no state change.
- REQ:
  - redirect_valid_o=1, flush_if_o=flush_id_o=1, ex_stall_o=1, busy_o=1.
  - redirect_pc_o is stable and must not change while valid=1 and ready=0.
  - On redirect_ready_i:
    - SQUASH_CYCLES=0: next state is IDLE.
    - Otherwise: load counter=SQUASH_CYCLES-1; next state is SQUASH.
  - valid stays high until accepted. No timeout.
- SQUASH:
  - redirect_valid_o=0, flush_if_o=flush_id_o=1, ex_stall_o=1, busy_o=1.
  - While counter≠0: decrement. When counter==0: next state is IDLE.
  - Total flush window after acceptance = SQUASH_CYCLES cycles.
- Latency:
  - Redirect request appears the cycle after the taken resolution.
  - Minimum taken-branch penalty = 1 (REQ) + SQUASH_CYCLES cycles when redirect_ready_i=1.
- br_valid_i while busy_o=1 is ignored: no latch, no statistics update. The simulation assertion "br_valid_i & busy_o never" fires with an error.
- Back-to-back taken branches: a second branch may resolve in the first IDLE cycle after SQUASH exits. It is handled identically.
- br_target_i is used as-is. No alignment or width change is applied; all 32 bits are latched.
- Reset asserted mid-REQ or mid-SQUASH aborts immediately to IDLE. The redirect is dropped and the counters are cleared.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: two CNT_W-bit counters.
  - stat_resolved_o increments on every accepted br_valid_i, i.e. in IDLE.
  - stat_taken_o increments when br_taken_i is also 1.
  - Both wrap modulo 2^CNT_W and are cleared only by reset.
- Undefined: the counters are not instantiated and both stat ports are tied to 0.

Test Plan:
- Reset then not-taken: br_valid_i=1, br_taken_i=0, target 0x0000_1234 -> no flush, redirect_valid_o=0, busy_o=0, redirect_pc_o stays 0.
- Taken, ready=1, SQUASH_CYCLES=2: branch at cycle N, target 0x0000_8000.
  - Cycle N: flush=1 combinationally.
  - Cycle N+1: redirect_valid_o=1, redirect_pc_o=0x0000_8000.
  - Cycles N+2 and N+3: flush=1, stall=1.
  - Cycle N+4: busy_o=0.
- Fetch backpressure: redirect_ready_i=0 for 5 cycles after a taken branch to 0xDEAD_BEE0 -> redirect_valid_o held 5 cycles, pc stable. Ready on the 6th cycle -> SQUASH begins the next cycle.
- SQUASH_CYCLES=0: taken branch with ready=1 -> REQ for exactly 1 cycle, then IDLE, with no SQUASH cycles.
- Async reset asserted mid-SQUASH, not aligned to a clock edge -> all outputs 0 immediately; next taken branch sequences normally.
- BRANCH_STATS_EN: 3 taken plus 2 not-taken resolutions -> stat_resolved_o=5, stat_taken_o=3. With CNT_W=4, 17 resolutions -> stat_resolved_o=1.
